// File: rtl/stack_pointer_unit.sv
// Stack pointer and PUSH/POP memory sequencer for the 16-bit CPU.
// SP skips the 0x0C00-wide MMIO window (bits 11:10 never set).
module stack_pointer_unit #(
  parameter logic [15:0] SP_INIT  = 16'hF3FF,
  parameter logic [15:0] SP_LIMIT = 16'h0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] push_data,
  input  logic        sp_load,
  input  logic [15:0] sp_load_val,
  output logic [15:0] SP,
  output logic        busy,
  output logic        done,
  output logic [15:0] pop_data,
  output logic        overflow,
  output logic        underflow,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD
  } state_t;

  state_t      state;
  logic [13:0] e;
  logic [13:0] e_inc;
  logic [13:0] e_dec;
  logic [15:0] sp_inc;
  logic [15:0] sp_dec;
  logic        full;
  logic        empty;

  // Compressed 14-bit form drops bits 11:10 so carries jump the gap.
  assign e      = {SP[15:12], SP[9:0]};
  assign e_inc  = e + 14'h0001;
  assign e_dec  = e + 14'h3FFF;
  assign sp_inc = {e_inc[13:10], 2'b00, e_inc[9:0]};
  assign sp_dec = {e_dec[13:10], 2'b00, e_dec[9:0]};
  assign full   = (SP == SP_LIMIT);
  assign empty  = (SP == SP_INIT);
  assign busy   = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= IDLE;
      SP        <= SP_INIT;
      pop_data  <= '0;
      mem_wdata <= '0;
      mem_addr  <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      done      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sp_load) begin
            SP <= {sp_load_val[15:12], 2'b00, sp_load_val[9:0]};
          end else if (push) begin
            if (full) begin
              overflow <= 1'b1;
            end else begin
              mem_wdata <= push_data;
              mem_addr  <= SP;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              state     <= WR;
            end
          end else if (pop) begin
            if (empty) begin
              underflow <= 1'b1;
            end else begin
              SP       <= sp_inc;
              mem_addr <= sp_inc;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              state    <= RD;
            end
          end
        end
        WR: begin
          if (mem_ack) begin
            SP      <= sp_dec;
            mem_req <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        RD: begin
          if (mem_ack) begin
            pop_data <= mem_rdata;
            mem_req  <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
